fetch_unit: RTL

//   PC register and IF/ID pipeline register. Sits directly upstream of the instruction memory:

---
 rtl/fetch_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// PC register and IF/ID pipeline register: drives the instruction memory address, captures the
// returned word and hands instruction, PC, link value and fetch-fault flags to decode.
module fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_END    = 32'h0000_4FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        exc_enter,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        is_jb_d,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        adel_d,
  output logic        bd_d
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_adel_q, ifid_adel_d;
  logic        ifid_bd_q, ifid_bd_d;
  logic        fetch_err;

  assign fetch_err = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q < IM_BASE)
                     || (fetch_pc_q > IM_END);

  // Next fetch PC; exception and eret win over a decode stall.
  always_comb begin
    fetch_pc_d = fetch_pc_q + 32'd4;
    if (exc_enter) begin
      fetch_pc_d = EXC_ENTRY;
    end else if (eret) begin
      fetch_pc_d = epc;
    end else if (stall) begin
      fetch_pc_d = fetch_pc_q;
    end else if (redirect) begin
      fetch_pc_d = redirect_pc;
    end
  end

  // Redirect does not squash IF/ID: the delay slot being fetched proceeds.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_adel_d  = ifid_adel_q;
    ifid_bd_d    = ifid_bd_q;
    if (exc_enter || eret || flush) begin
      ifid_instr_d = 32'h0;
      ifid_pc_d    = fetch_pc_q;
      ifid_adel_d  = 1'b0;
      ifid_bd_d    = 1'b0;
    end else if (!stall) begin
      ifid_pc_d = fetch_pc_q;
      ifid_bd_d = is_jb_d;
      if (fetch_err) begin
        // Faulting fetch becomes a nop tagged with AdEL; memory output is ignored.
        ifid_instr_d = 32'h0;
        ifid_adel_d  = 1'b1;
      end else begin
        ifid_instr_d = instr_f;
        ifid_adel_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= PC_RESET;
      ifid_instr_q <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_adel_q  <= 1'b0;
      ifid_bd_q    <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_adel_q  <= ifid_adel_d;
      ifid_bd_q    <= ifid_bd_d;
    end
  end

  assign pc_f    = fetch_pc_q;
  assign instr_d = ifid_instr_q;
  assign pc_d    = ifid_pc_q;
  assign pc8_d   = ifid_pc_q + 32'd8;
  assign adel_d  = ifid_adel_q;
  assign bd_d    = ifid_bd_q;

endmodule
